// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (inhibit, request-to-
//               send, device-clocked data, ACK check) with open-drain enables.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       send_req,
    input  logic [7:0] send_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       timeout,
    input  logic       kb_clk,
    input  logic       data,
    output logic       kb_clk_drive_low,
    output logic       data_drive_low
);

    localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_RTS       = 3'd2;
    localparam logic [2:0] c_SEND      = 3'd3;
    localparam logic [2:0] c_ACK       = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_clk_f, r_fall;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [c_TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [7:0]         r_byte, w_byte_nxt;
    logic               r_par, w_par_nxt;
    logic               r_ack, w_ack_nxt;
    logic               r_clk_drv, w_clk_drv_nxt;
    logic               r_dat_drv, w_dat_drv_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ackerr, w_ackerr_nxt;
    logic               r_to, w_to_nxt;
    logic               w_to_hit;

    // Line conditioning: lines idle high, so every stage resets to 1.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= '1;
            r_clk_f  <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_clk_s1 <= kb_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= data;
            r_dat_s2 <= r_dat_s1;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
            if (&r_filt) begin
                r_clk_f <= 1'b1;
            end else if (~|r_filt) begin
                r_clk_f <= 1'b0;
            end
            r_fall   <= r_clk_f & ~|r_filt;
        end
    end

    assign w_to_hit = (r_to_cnt == c_TO_LAST);

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (send_req) w_state_nxt = c_INHIBIT;
            c_INHIBIT:   if (r_inh_cnt == c_INH_LAST) w_state_nxt = c_RTS;
            c_RTS:       w_state_nxt = c_SEND;
            c_SEND: begin
                if (w_to_hit)                           w_state_nxt = c_IDLE;
                else if (r_fall && r_idx == 4'd9)       w_state_nxt = c_ACK;
            end
            c_ACK: begin
                if (w_to_hit)                           w_state_nxt = c_IDLE;
                else if (r_fall)                        w_state_nxt = c_WAIT_IDLE;
            end
            c_WAIT_IDLE: begin
                if (w_to_hit || (r_clk_f && r_dat_s2))  w_state_nxt = c_IDLE;
            end
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    // Timeout is checked ahead of fall so it wins when both land together.
    always_comb begin
        w_inh_cnt_nxt = r_inh_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_idx_nxt     = r_idx;
        w_byte_nxt    = r_byte;
        w_par_nxt     = r_par;
        w_ack_nxt     = r_ack;
        w_clk_drv_nxt = r_clk_drv;
        w_dat_drv_nxt = r_dat_drv;
        w_done_nxt    = 1'b0;
        w_ackerr_nxt  = 1'b0;
        w_to_nxt      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_clk_drv_nxt = 1'b0;
                w_dat_drv_nxt = 1'b0;
                if (send_req) begin
                    w_byte_nxt    = send_data;
                    w_par_nxt     = ~^send_data;
                    w_inh_cnt_nxt = '0;
                    w_clk_drv_nxt = 1'b1;
                end
            end
            c_INHIBIT: begin
                w_inh_cnt_nxt = r_inh_cnt + 1'b1;
                if (r_inh_cnt == c_INH_LAST) w_dat_drv_nxt = 1'b1;
            end
            c_RTS: begin
                w_clk_drv_nxt = 1'b0;
                w_idx_nxt     = '0;
                w_to_cnt_nxt  = '0;
            end
            c_SEND, c_ACK, c_WAIT_IDLE: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (w_to_hit) begin
                    w_clk_drv_nxt = 1'b0;
                    w_dat_drv_nxt = 1'b0;
                    w_to_nxt      = 1'b1;
                end else begin
                    if (r_fall) w_to_cnt_nxt = '0;
                    if (r_state == c_SEND && r_fall) begin
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx < 4'd8)       w_dat_drv_nxt = ~r_byte[r_idx[2:0]];
                        else if (r_idx == 4'd8) w_dat_drv_nxt = ~r_par;
                        else                    w_dat_drv_nxt = 1'b0;
                    end
                    if (r_state == c_ACK && r_fall) w_ack_nxt = r_dat_s2;
                    if (r_state == c_WAIT_IDLE && r_clk_f && r_dat_s2) begin
                        w_done_nxt   = ~r_ack;
                        w_ackerr_nxt = r_ack;
                    end
                end
            end
            default: begin
                w_clk_drv_nxt = 1'b0;
                w_dat_drv_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_idx     <= '0;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_ack     <= 1'b0;
            r_clk_drv <= 1'b0;
            r_dat_drv <= 1'b0;
            r_done    <= 1'b0;
            r_ackerr  <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_inh_cnt <= w_inh_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_byte    <= w_byte_nxt;
            r_par     <= w_par_nxt;
            r_ack     <= w_ack_nxt;
            r_clk_drv <= w_clk_drv_nxt;
            r_dat_drv <= w_dat_drv_nxt;
            r_done    <= w_done_nxt;
            r_ackerr  <= w_ackerr_nxt;
            r_to      <= w_to_nxt;
        end
    end

    assign busy             = (r_state != c_IDLE);
    assign done             = r_done;
    assign ack_error        = r_ackerr;
    assign timeout          = r_to;
    assign kb_clk_drive_low = r_clk_drv;
    assign data_drive_low   = r_dat_drv;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with an open-drain device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH  = 20;
    localparam int c_TO   = 2000;
    localparam int c_HALF = 40;

    typedef struct {
        logic [7:0] byte_v;
        logic       ack_low;
        logic       glitch;
        logic       poke;
        logic [9:0] exp_rx;
        logic       exp_done;
    } vec_t;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic       send_req;
    logic [7:0] send_data;
    logic       busy, done, ack_error, timeout;
    logic       kb_clk_drive_low, data_drive_low;
    logic       dev_clk_low, dev_data_low;
    wire        kb_clk = ~(kb_clk_drive_low | dev_clk_low);
    wire        data   = ~(data_drive_low | dev_data_low);

    int n_vec = 0;
    int n_bad = 0;

    logic mon_clr = 1'b0;
    int   cyc = 0, cnt_done = 0, cnt_ackerr = 0, cnt_to = 0, to_cyc = 0;
    int   inh_cycles = 0, busy_rises = 0, busy_gap = 0, last_fall_cyc = 0;
    logic dat_at_release = 1'b0;
    logic prev_cdrv = 1'b0, prev_busy = 1'b0, prev_kbclk = 1'b1;

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INH),
        .TIMEOUT_CYCLES (c_TO),
        .FILTER_LEN     (8)
    ) dut (
        .VGA_clk          (VGA_clk),
        .reset            (reset),
        .send_req         (send_req),
        .send_data        (send_data),
        .busy             (busy),
        .done             (done),
        .ack_error        (ack_error),
        .timeout          (timeout),
        .kb_clk           (kb_clk),
        .data             (data),
        .kb_clk_drive_low (kb_clk_drive_low),
        .data_drive_low   (data_drive_low)
    );

    always #5 VGA_clk = ~VGA_clk;

    always @(negedge VGA_clk) begin
        cyc++;
        if (mon_clr) begin
            cnt_done = 0; cnt_ackerr = 0; cnt_to = 0; inh_cycles = 0;
            busy_rises = 0; busy_gap = 0; dat_at_release = 1'b0;
        end else begin
            if (done) cnt_done++;
            if (ack_error) cnt_ackerr++;
            if (timeout) begin cnt_to++; to_cyc = cyc; end
            if (kb_clk_drive_low && !data_drive_low) inh_cycles++;
            if (prev_cdrv && !kb_clk_drive_low) dat_at_release = data_drive_low;
            if (busy && !prev_busy) busy_rises++;
            if (busy_rises > 0 && !busy && (cnt_done + cnt_ackerr + cnt_to) == 0) busy_gap++;
        end
        if (prev_kbclk && !kb_clk) last_fall_cyc = cyc;
        prev_cdrv  = kb_clk_drive_low;
        prev_busy  = busy;
        prev_kbclk = kb_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge VGA_clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge VGA_clk);
        #1 send_req = 1'b1; send_data = b;
        @(posedge VGA_clk);
        #1 send_req = 1'b0;
    endtask

    // Device side: waits for request-to-send, then clocks up to nfalls edges.
    task automatic device_rx(input int nfalls, input logic ack_low, input logic glitch,
                             output logic [9:0] rx, output logic ok);
        int w;
        rx = '0; ok = 1'b0; w = 0;
        @(negedge VGA_clk);
        while (!(kb_clk_drive_low == 1'b0 && data_drive_low == 1'b1) && w < 1000) begin
            @(negedge VGA_clk);
            w++;
        end
        if (w >= 1000) return;
        ok = 1'b1;
        repeat (20) @(posedge VGA_clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            if (i < nfalls) begin
                dev_clk_low = 1'b1;
                repeat (c_HALF) @(posedge VGA_clk);
                #1;
                if (i < 10) rx[i] = data;
                dev_clk_low = 1'b0;
                if (i == 9 && ack_low) dev_data_low = 1'b1;
                if (i == 10) begin
                    repeat (5) @(posedge VGA_clk);
                    #1 dev_data_low = 1'b0;
                end
                if (glitch && i < 10) begin
                    repeat (12) @(posedge VGA_clk);
                    #1 dev_clk_low = 1'b1;
                    repeat (3) @(posedge VGA_clk);
                    #1 dev_clk_low = 1'b0;
                    repeat (c_HALF - 15) @(posedge VGA_clk);
                end else begin
                    repeat (c_HALF) @(posedge VGA_clk);
                end
                #1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [9:0] rx;
        logic       ok;
        int         w;
        mon_clear();
        fork
            send_byte(v.byte_v);
            device_rx(11, v.ack_low, v.glitch, rx, ok);
            if (v.poke) begin
                repeat (300) @(posedge VGA_clk);
                #1 send_req = 1'b1; send_data = 8'hAA;
                @(posedge VGA_clk);
                #1 send_req = 1'b0;
            end
        join
        w = 0;
        while ((cnt_done + cnt_ackerr + cnt_to) == 0 && w < 400) begin
            @(negedge VGA_clk);
            w++;
        end
        repeat (200) @(negedge VGA_clk);
        check($sformatf("v%0d_rts_seen", idx), 32'(ok), 32'd1);
        check($sformatf("v%0d_rx_bits", idx), 32'(rx), 32'(v.exp_rx));
        check($sformatf("v%0d_done_cnt", idx), cnt_done, 32'(v.exp_done));
        check($sformatf("v%0d_ackerr_cnt", idx), cnt_ackerr, 32'(!v.exp_done));
        check($sformatf("v%0d_timeout_cnt", idx), cnt_to, 0);
        check($sformatf("v%0d_inhibit_cycles", idx), inh_cycles, c_INH);
        check($sformatf("v%0d_data_low_at_clk_release", idx), 32'(dat_at_release), 32'd1);
        check($sformatf("v%0d_busy_gap", idx), busy_gap, 0);
        check($sformatf("v%0d_busy_rises", idx), busy_rises, 1);
        check($sformatf("v%0d_lines_released", idx), {30'd0, kb_clk_drive_low, data_drive_low}, 0);
        check($sformatf("v%0d_busy_end", idx), 32'(busy), 0);
    endtask

    vec_t       vecs[5];
    vec_t       v_ff;
    logic [9:0] rx_p;
    logic       ok_p;
    int         w;

    initial begin
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 10'h3ED, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 10'h300, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 10'h201, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 10'h35A, 1'b0};
        vecs[4] = '{8'hED, 1'b1, 1'b1, 1'b1, 10'h3ED, 1'b1};
        v_ff    = '{8'hFF, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1};

        reset = 1'b1; send_req = 1'b0; send_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(posedge VGA_clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ack_error", 32'(ack_error), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_clk_drive", 32'(kb_clk_drive_low), 0);
        check("rst_data_drive", 32'(data_drive_low), 0);
        reset = 1'b0;
        repeat (20) @(posedge VGA_clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Device stalls after four falls; host must time out then recover.
        mon_clear();
        fork
            send_byte(8'hED);
            device_rx(4, 1'b1, 1'b0, rx_p, ok_p);
        join
        w = 0;
        while (cnt_to == 0 && w < 2300) begin
            @(negedge VGA_clk);
            w++;
        end
        repeat (5) @(negedge VGA_clk);
        check("to_pulse_cnt", cnt_to, 1);
        check_range("to_delay_after_last_fall", to_cyc - last_fall_cyc, c_TO, c_TO + 30);
        check("to_done_cnt", cnt_done, 0);
        check("to_ackerr_cnt", cnt_ackerr, 0);
        check("to_lines_released", {30'd0, kb_clk_drive_low, data_drive_low}, 0);
        check("to_busy", 32'(busy), 0);
        run_vec(v_ff, 5);

        // Asynchronous reset in the middle of the data bits.
        mon_clear();
        fork
            send_byte(8'hED);
            device_rx(5, 1'b1, 1'b0, rx_p, ok_p);
        join
        check("mid_busy_before_reset", 32'(busy), 1);
        check("mid_data_drive_before_reset", 32'(data_drive_low), 1);
        @(posedge VGA_clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_clk_drive", 32'(kb_clk_drive_low), 0);
        check("mid_rst_data_drive", 32'(data_drive_low), 0);
        check("mid_rst_busy", 32'(busy), 0);
        repeat (4) @(posedge VGA_clk);
        #1 reset = 1'b0;
        repeat (100) @(negedge VGA_clk);
        check("mid_rst_no_pulses", cnt_done + cnt_ackerr + cnt_to, 0);
        check("mid_rst_busy_after", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
